// File: rtl/osd_wb_mem_slave_if.sv
// Wishbone B3 bus bundle between a master and osd_wb_mem_slave.
// err_o exists only when WB_MEM_SLAVE_ERR_EN is defined.
interface osd_wb_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int SW = DATA_WIDTH / 8;

    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SW-1:0]         sel_i;
    logic [2:0]            cti_i;
    logic [1:0]            bte_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;

`ifdef WB_MEM_SLAVE_ERR_EN
    logic                  err_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        input  dat_o, ack_o, err_o
    );
    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        output dat_o, ack_o, err_o
    );
`else
    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        input  dat_o, ack_o
    );
    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        output dat_o, ack_o
    );
`endif
endinterface

// File: rtl/osd_wb_mem_slave.sv
// Wishbone B3 memory slave: classic cycles plus incrementing/wrapping bursts at one beat per cycle.
// Optional feature macro: WB_MEM_SLAVE_ERR_EN (out-of-range beats answered with err_o).
module osd_wb_mem_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    osd_wb_mem_slave_if.slave wb
);
    localparam int SW   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(SW);
    localparam int IDXW = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH + 1)'(MEM_WORDS * SW);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(SW);
    localparam logic [2:0] CTI_CONST = 3'b001;
    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam logic [2:0] CTI_EOB   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SINGLE = 2'b01,
        S_BURST  = 2'b10
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [2:0]            r_cti;
    logic [1:0]            r_bte;
    logic [DATA_WIDTH-1:0] r_dat;

    logic                  w_start;
    logic                  w_ack_q;
    logic                  w_beat;
    logic                  w_in_range;
    logic                  w_xfer;
    logic                  w_err_beat;
    logic                  w_end_beat;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_nxt_in_range;
    logic [DATA_WIDTH-1:0] w_rd_start;
    logic [DATA_WIDTH-1:0] w_rd_cur;
    logic [DATA_WIDTH-1:0] w_rd_nxt;
    logic [DATA_WIDTH-1:0] w_la_dat;
    logic [DATA_WIDTH-1:0] w_dat_nxt;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[ADDR_WIDTH] && (diff < SPAN);
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDXW'(off >> OFFW);
    endfunction

    // Wrapping bursts only advance the low bits covered by the wrap window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0]            cti,
                                                        input logic [1:0]            bte);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc = a + STEP;
        case (bte)
            2'b01:   mask = ADDR_WIDTH'((SW * 4) - 1);
            2'b10:   mask = ADDR_WIDTH'((SW * 8) - 1);
            2'b11:   mask = ADDR_WIDTH'((SW * 16) - 1);
            default: mask = {ADDR_WIDTH{1'b1}};
        endcase
        if (cti == CTI_CONST) begin
            return a;
        end else begin
            return (a & ~mask) | (inc & mask);
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [SW-1:0]         sel);
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < SW; b++) begin
            if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign w_start        = wb.cyc_i & wb.stb_i;
    assign w_in_range     = in_window(r_addr);
    assign w_addr_nxt     = next_addr(r_addr, r_cti, r_bte);
    assign w_nxt_in_range = in_window(w_addr_nxt);
    assign w_rd_start     = in_window(wb.adr_i) ? r_mem[word_idx(wb.adr_i)] : {DATA_WIDTH{1'b0}};
    assign w_rd_cur       = w_in_range ? r_mem[word_idx(r_addr)] : {DATA_WIDTH{1'b0}};
    assign w_rd_nxt       = w_nxt_in_range ? r_mem[word_idx(w_addr_nxt)] : {DATA_WIDTH{1'b0}};
    // Lookahead sees the beat being written this cycle when it targets the same word.
    assign w_la_dat       = (r_we && w_in_range && w_nxt_in_range &&
                             (word_idx(w_addr_nxt) == word_idx(r_addr)))
                            ? merge_lanes(w_rd_nxt, wb.dat_i, wb.sel_i) : w_rd_nxt;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ((wb.cti_i == CTI_CONST) || (wb.cti_i == CTI_INCR)) ? S_BURST : S_SINGLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SINGLE: w_state_nxt = S_IDLE;
            S_BURST: begin
                if (!wb.cyc_i || w_end_beat) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BURST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: acknowledge gating and error split
    always_comb begin
        case (r_state)
            S_SINGLE, S_BURST: w_ack_q = 1'b1;
            default:           w_ack_q = 1'b0;
        endcase
        w_beat = w_ack_q & wb.cyc_i & wb.stb_i;
`ifdef WB_MEM_SLAVE_ERR_EN
        w_xfer     = w_beat & w_in_range;
        w_err_beat = w_beat & ~w_in_range;
`else
        w_xfer     = w_beat;
        w_err_beat = 1'b0;
`endif
        w_end_beat = (w_xfer && (wb.cti_i == CTI_EOB)) || w_err_beat;
    end

    assign wb.ack_o = w_xfer;
    assign wb.dat_o = r_dat;
`ifdef WB_MEM_SLAVE_ERR_EN
    assign wb.err_o = w_err_beat;
`endif

    // Next read data: start word, lookahead after a transfer, or hold during a wait state
    always_comb begin
        w_dat_nxt = {DATA_WIDTH{1'b0}};
        if (r_state == S_IDLE) begin
            if (w_start) begin
                w_dat_nxt = w_rd_start;
            end else begin
                w_dat_nxt = {DATA_WIDTH{1'b0}};
            end
        end else if ((r_state == S_BURST) && (w_state_nxt == S_BURST)) begin
            if (w_xfer) begin
                w_dat_nxt = w_la_dat;
            end else begin
                w_dat_nxt = w_rd_cur;
            end
        end else begin
            w_dat_nxt = {DATA_WIDTH{1'b0}};
        end
    end

    // Cycle context latched at start; address advances on each burst transfer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= {ADDR_WIDTH{1'b0}};
            r_we   <= 1'b0;
            r_cti  <= 3'b000;
            r_bte  <= 2'b00;
            r_dat  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_dat <= w_dat_nxt;
            if ((r_state == S_IDLE) && w_start) begin
                r_addr <= wb.adr_i;
                r_we   <= wb.we_i;
                r_cti  <= wb.cti_i;
                r_bte  <= wb.bte_i;
            end else if ((r_state == S_BURST) && w_xfer) begin
                r_addr <= w_addr_nxt;
            end
        end
    end

    // Memory array: byte-lane writes on accepted in-range write beats, never reset
    always_ff @(posedge clk_i) begin
        if (w_xfer && r_we && w_in_range) begin
            for (int b = 0; b < SW; b++) begin
                if (wb.sel_i[b]) r_mem[word_idx(r_addr)][8*b +: 8] <= wb.dat_i[8*b +: 8];
            end
        end
    end
endmodule
